rv_multicycle_core: RTL and testbench
=====================================

# rv_multicycle_core

Parametrised multi-cycle RV32I-subset integer core: fetches from an external synchronous-read instruction memory, decodes, executes on an internal ALU, and writes back to an internal register file. It generalises the single-step fetch/decode/register-read datapath into a complete FSM-sequenced core with configurable data width, register count and memory depth, plus retire reporting, halt and illegal-instruction handling. It sits between the instruction memory and the top-level test/FPGA wrapper.

## Interface
- XLEN, 32, datapath and register width (≥32; immediates sign-extended to XLEN)
- NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E; rs/rd ≥ NUM_REGS is illegal)
- IMEM_DEPTH, 64, instruction words addressable; AW = $clog2(IMEM_DEPTH)
- RESET_PC, 0, byte address loaded into pc on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  AW  word address = pc[AW+1:2]
- imem_rdata  in  32  instruction, valid one cycle after imem_addr
- pc  out  XLEN  current instruction byte address
- retire_valid  out  1  one-cycle pulse per retired instruction
- retire_rd  out  5  destination register of retired instruction
- retire_data  out  XLEN  value written (0 if rd = x0)
- halted  out  1  core stopped (EBREAK or illegal)
- illegal  out  1  stop cause was an illegal instruction

## Operation
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH; terminal HALT.
- FETCH: drive imem_addr from pc.
- DECODE: latch imem_rdata into ir; read rs1/rs2; classify. Illegal opcode/funct3/funct7 or out-of-range reg → HALT with illegal=1. EBREAK (0x00100073) → HALT with illegal=0.
- Supported: ADDI SLTI SLTIU XORI ORI ANDI; ADD SUB SLT SLTU XOR OR AND. Shifts per Configuration.
- EXECUTE: ALU operand B = sign-extended imm[31:20] (I-type) or rs2 (R-type); result latched in alu_q.
- WRITEBACK: write alu_q to rd unless rd = 0; pc ← pc + 4; pulse retire_valid with retire_rd/retire_data.
- x0 reads 0 always; writes discarded.
- Arithmetic modulo 2^XLEN; SLT signed, SLTU unsigned; SLTIU compares against sign-extended imm as unsigned.
- pc wraps modulo 2^XLEN; imem_addr wraps modulo IMEM_DEPTH via truncation.
- HALT is sticky until rst; no further imem access changes, no retires.

## Timing
- Reset values: pc = RESET_PC, state = FETCH, all registers 0, retire_valid = 0, retire_rd = 0, retire_data = 0, halted = 0, illegal = 0, imem_addr = RESET_PC[AW+1:2].
- Each instruction: 4 cycles; retire_valid asserted in the WRITEBACK cycle; first retire on 4th rising edge after rst deasserts.
- Register written on the WRITEBACK→FETCH edge; next instruction's DECODE sees the new value (no hazards).
- halted/illegal rise on the edge leaving DECODE; the halting instruction does not retire and pc stays at its address.
- rst asserted mid-instruction: immediate abort, all state to reset values, in-flight write discarded.

## Configuration
- RV_SHIFT_EN defined: SLLI SRLI SRAI SLL SRL SRA supported; shift amount = low $clog2(XLEN) bits of operand B; SLLI/SRLI/SRAI with imm[11:5] other than 0000000/0100000 (SRAI) illegal.
- Undefined: all shift encodings (funct3 001/101 for opcodes 0010011/0110011) are illegal → HALT, illegal=1.

## Structure
- Package rv_pkg: opcode constants (OP_IMM 7'b0010011, OP 7'b0110011, SYSTEM 7'b1110011), funct3 constants, EBREAK encoding, state enum, alu_op_e enum.
- Sub-module rv_alu: combinational, parametrised XLEN, inputs alu_op_e + two operands, output result.
- Register file and FSM inside the core.

## Test plan
- Program ADDI x1,x0,5; ADDI x2,x0,3; ADD x3,x1,x2; ADDI x4,x0,10; ADD x5,x3,x4; EBREAK → five retires 4 cycles apart, x5 = 18, halted=1, illegal=0, pc = 0x14.
- ADDI x1,x0,3; SUB x2,x0,x1; SLT x3,x2,x0; SLTU x4,x2,x0 → x2 = 0xFFFFFFFD, x3 = 1, x4 = 0.
- ADDI x0,x0,7; ADD x1,x0,x0 → retire_data 0, x1 = 0.
- Word 0x0000006F (JAL) → halted=1, illegal=1, no retire, pc unchanged.
- rst pulsed during EXECUTE of ADDI x1,x0,9 → x1 stays 0, pc = RESET_PC, execution restarts from word 0.
- SLLI x2,x1,4 with x1 = 1 → x2 = 16 with RV_SHIFT_EN; halted=1, illegal=1 without.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core:
// opcode/funct constants, the EBREAK encoding, FSM states and ALU operations.
package rv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

endpackage

// File: rtl/rv_multicycle_core_if.sv
// Core-side bus: instruction memory port plus the retire report.
// The master side is the core; the slave side is memory / the wrapper.
interface rv_multicycle_core_if #(
  parameter int AW   = 6,
  parameter int XLEN = 32
);
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata;
  logic            retire_valid;
  logic [4:0]      retire_rd;
  logic [XLEN-1:0] retire_data;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output retire_valid,
    output retire_rd,
    output retire_data
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  retire_valid,
    input  retire_rd,
    input  retire_data
  );
endinterface

// File: rtl/rv_alu.sv
// Combinational integer ALU. Shift amount is the low $clog2(XLEN) bits of b.
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  // Select the operation; comparisons produce a zero-extended single bit.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with a sticky HALT on EBREAK or an illegal instruction.
// Optional feature macro: RV_SHIFT_EN enables SLLI/SRLI/SRAI/SLL/SRL/SRA;
// without it every shift encoding is treated as illegal.
module rv_multicycle_core
  import rv_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NUM_REGS   = 32,
  parameter int          IMEM_DEPTH = 64,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  rv_multicycle_core_if.master bus,
  output logic [XLEN-1:0]      pc,
  output logic                 halted,
  output logic                 illegal
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  state_e state, state_next;

  logic [XLEN-1:0] rf [NUM_REGS];

  logic [4:0]      rd_q;
  alu_op_e         alu_op_q;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] alu_result;
  logic            illegal_q;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  alu_op_e dec_op;
  logic    dec_legal;
  logic    dec_ebreak;
  logic    dec_use_rs2;

  function automatic logic reg_ok(input logic [4:0] r);
    return {27'd0, r} < 32'(NUM_REGS);
  endfunction

  assign opcode   = bus.imem_rdata[6:0];
  assign rd       = bus.imem_rdata[11:7];
  assign funct3   = bus.imem_rdata[14:12];
  assign rs1      = bus.imem_rdata[19:15];
  assign rs2      = bus.imem_rdata[24:20];
  assign funct7   = bus.imem_rdata[31:25];
  assign imm_sext = {{(XLEN-12){bus.imem_rdata[31]}}, bus.imem_rdata[31:20]};

  assign bus.imem_addr = pc[AW+1:2];
  assign illegal       = illegal_q;

  // Register-file read ports; x0 and out-of-range indices read as zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && reg_ok(rs1)) rs1_val = rf[rs1[RW-1:0]];
    if (rs2 != 5'd0 && reg_ok(rs2)) rs2_val = rf[rs2[RW-1:0]];
  end

  // Classify the fetched word into an ALU operation and a legality verdict.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_legal   = 1'b0;
    dec_ebreak  = 1'b0;
    dec_use_rs2 = 1'b0;
    if (bus.imem_rdata == EBREAK_INSN) begin
      dec_ebreak = 1'b1;
    end else if (opcode == OP_IMM) begin
      dec_legal = reg_ok(rd) && reg_ok(rs1);
      case (funct3)
        F3_ADD:  dec_op = ALU_ADD;
        F3_SLT:  dec_op = ALU_SLT;
        F3_SLTU: dec_op = ALU_SLTU;
        F3_XOR:  dec_op = ALU_XOR;
        F3_OR:   dec_op = ALU_OR;
        F3_AND:  dec_op = ALU_AND;
`ifdef RV_SHIFT_EN
        F3_SLL: begin
          dec_op = ALU_SLL;
          if (funct7 != F7_BASE) dec_legal = 1'b0;
        end
        F3_SRL: begin
          if (funct7 == F7_BASE)     dec_op = ALU_SRL;
          else if (funct7 == F7_ALT) dec_op = ALU_SRA;
          else                       dec_legal = 1'b0;
        end
`endif
        default: dec_legal = 1'b0;
      endcase
    end else if (opcode == OP) begin
      dec_use_rs2 = 1'b1;
      dec_legal   = reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
      if (funct7 == F7_BASE) begin
        case (funct3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_OR:   dec_op = ALU_OR;
          F3_AND:  dec_op = ALU_AND;
`ifdef RV_SHIFT_EN
          F3_SLL:  dec_op = ALU_SLL;
          F3_SRL:  dec_op = ALU_SRL;
`endif
          default: dec_legal = 1'b0;
        endcase
      end else if (funct7 == F7_ALT) begin
        case (funct3)
          F3_ADD:  dec_op = ALU_SUB;
`ifdef RV_SHIFT_EN
          F3_SRL:  dec_op = ALU_SRA;
`endif
          default: dec_legal = 1'b0;
        endcase
      end else begin
        dec_legal = 1'b0;
      end
    end
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .result (alu_result)
  );

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Sequencing plus the retire report and halt status for the current state.
  always_comb begin
    state_next       = state;
    bus.retire_valid = 1'b0;
    bus.retire_rd    = 5'd0;
    bus.retire_data  = '0;
    halted           = 1'b0;
    case (state)
      S_FETCH:     state_next = S_DECODE;
      S_DECODE:    state_next = (dec_ebreak || !dec_legal) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        state_next       = S_FETCH;
        bus.retire_valid = 1'b1;
        bus.retire_rd    = rd_q;
        bus.retire_data  = (rd_q == 5'd0) ? '0 : alu_q;
      end
      S_HALT: begin
        state_next = S_HALT;
        halted     = 1'b1;
      end
      default:     state_next = S_FETCH;
    endcase
  end

  // Datapath: operand capture, ALU result latch, register write and pc step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= XLEN'(RESET_PC);
      rd_q      <= 5'd0;
      alu_op_q  <= ALU_ADD;
      op_a_q    <= '0;
      op_b_q    <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          if (!dec_ebreak && !dec_legal) begin
            illegal_q <= 1'b1;
          end else if (!dec_ebreak) begin
            rd_q     <= rd;
            alu_op_q <= dec_op;
            op_a_q   <= rs1_val;
            op_b_q   <= dec_use_rs2 ? rs2_val : imm_sext;
          end
        end
        S_EXECUTE: alu_q <= alu_result;
        S_WRITEBACK: begin
          if (rd_q != 5'd0) rf[rd_q[RW-1:0]] <= alu_q;
          pc <= pc + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Bench for rv_multicycle_core: directed program table, reset-abort sequences
// and random programs checked cycle by cycle against an instruction-level model.
module tb_rv_multicycle_core;

`ifdef RV_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  localparam int DEPTH = 64;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        halted;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [DEPTH];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          model_h;
  bit          model_ill;
  logic [31:0] mregs [32];

  typedef struct {
    string       name;
    logic [31:0] prog [8];
    int          len;
    int          exp_retires;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          exp_ill;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [7];

  rv_multicycle_core_if #(.AW(6), .XLEN(32)) bus_if ();

  rv_multicycle_core #(
    .XLEN(32), .NUM_REGS(32), .IMEM_DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .pc      (pc),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) bus_if.imem_rdata <= mem[bus_if.imem_addr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3, input int rd);
    logic [11:0] i12;
    logic [4:0]  s1;
    logic [4:0]  d;
    i12 = imm[11:0];
    s1  = rs1[4:0];
    d   = rd[4:0];
    return {i12, s1, f3, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input logic [2:0] f3, input int rd);
    logic [4:0] s2;
    logic [4:0] s1;
    logic [4:0] d;
    s2 = rs2[4:0];
    s1 = rs1[4:0];
    d  = rd[4:0];
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  // Reference arithmetic for one funct3 slot; alt selects SUB/SRA.
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    r  = 32'd0;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> sh;
        else     r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Architectural effect of one instruction word on the model registers.
  function automatic void model_exec(input logic [31:0] w, output bit stop, output bit ill,
                                     output logic [4:0] rd_o, output logic [31:0] val);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    bit          ok;
    op   = w[6:0];
    f3   = w[14:12];
    f7   = w[31:25];
    rd_o = w[11:7];
    a    = mregs[w[19:15]];
    b    = (op == 7'b0110011) ? mregs[w[24:20]] : {{20{w[31]}}, w[31:20]};
    stop = 1'b0;
    ill  = 1'b0;
    val  = 32'd0;
    ok   = 1'b0;
    if (w == EBRK) begin
      stop = 1'b1;
      return;
    end
    if (op == 7'b0010011) begin
      if (f3 == 3'd1)      ok = SHIFT_EN && f7 == 7'h00;
      else if (f3 == 3'd5) ok = SHIFT_EN && (f7 == 7'h00 || f7 == 7'h20);
      else                 ok = 1'b1;
      val = ref_alu(f3, (f3 == 3'd5) && f7 == 7'h20, a, b);
    end else if (op == 7'b0110011) begin
      if (f7 == 7'h00)      ok = (f3 == 3'd1 || f3 == 3'd5) ? SHIFT_EN : 1'b1;
      else if (f7 == 7'h20) ok = (f3 == 3'd0) || (f3 == 3'd5 && SHIFT_EN);
      val = ref_alu(f3, f7 == 7'h20, a, b);
    end
    if (!ok) begin
      stop = 1'b1;
      ill  = 1'b1;
      val  = 32'd0;
      return;
    end
    if (rd_o == 5'd0) val = 32'd0;
    else              mregs[rd_o] = val;
  endfunction

  // Walk the program in mem from pc 0, recording retires and the halt point.
  task automatic model_run();
    logic [31:0] pcm;
    bit          stop;
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] val;
    exp_t        e;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    exp_q.delete();
    pcm       = 32'd0;
    model_h   = 70;
    model_ill = 1'b0;
    for (int k = 0; k < 70; k++) begin
      model_exec(mem[(pcm >> 2) % DEPTH], stop, ill, rd, val);
      if (stop) begin
        model_h   = k;
        model_ill = ill;
        break;
      end
      e.rd   = rd;
      e.data = val;
      exp_q.push_back(e);
      pcm = pcm + 32'd4;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
  endtask

  task automatic applyStimulus(input int idx);
    clear_mem();
    for (int i = 0; i < vecs[idx].len; i++) mem[i] = vecs[idx].prog[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pc", pc, 64'd0);
    checkOutput("reset imem_addr", bus_if.imem_addr, 64'd0);
    checkOutput("reset retire_valid", bus_if.retire_valid, 64'd0);
    checkOutput("reset retire_rd", bus_if.retire_rd, 64'd0);
    checkOutput("reset retire_data", bus_if.retire_data, 64'd0);
    checkOutput("reset halted", halted, 64'd0);
    checkOutput("reset illegal", illegal, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset, then check every cycle against the model until well past the halt.
  task automatic run_case(output int n_ret, output logic [4:0] last_rd, output logic [31:0] last_data);
    bit          exp_rv;
    int          slot;
    logic [31:0] exp_pc;
    model_run();
    do_reset();
    n_ret     = 0;
    last_rd   = 5'd0;
    last_data = 32'd0;
    for (int c = 1; c <= 4 * model_h + 8; c++) begin
      @(posedge clk);
      #1;
      slot   = c / 4;
      exp_rv = (c % 4 == 3) && (slot < model_h);
      checkOutput($sformatf("retire_valid c%0d", c), bus_if.retire_valid, exp_rv);
      if (bus_if.retire_valid) begin
        n_ret++;
        last_rd   = bus_if.retire_rd;
        last_data = bus_if.retire_data;
      end
      if (exp_rv) begin
        checkOutput($sformatf("retire_rd c%0d", c), bus_if.retire_rd, exp_q[slot].rd);
        checkOutput($sformatf("retire_data c%0d", c), bus_if.retire_data, exp_q[slot].data);
      end
      checkOutput($sformatf("halted c%0d", c), halted, c >= 4 * model_h + 2);
      exp_pc = 32'(4 * ((slot < model_h) ? slot : model_h));
      checkOutput($sformatf("pc c%0d", c), pc, exp_pc);
      checkOutput($sformatf("imem_addr c%0d", c), bus_if.imem_addr, exp_pc[7:2]);
    end
    checkOutput("illegal", illegal, model_ill);
  endtask

  function automatic logic [31:0] rand_insn();
    int          kind;
    int          f3;
    int          imm;
    logic [6:0]  f7;
    kind = int'($urandom_range(0, 19));
    f3   = int'($urandom_range(0, 7));
    f7   = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (kind < 12) begin
      imm = int'($urandom);
      if (f3 == 1 || f3 == 5) imm = {20'd0, f7, imm[4:0]};
      return enc_i(imm, int'($urandom_range(0, 7)), f3[2:0], int'($urandom_range(0, 7)));
    end else if (kind < 19) begin
      return enc_r(f7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), f3[2:0],
                   int'($urandom_range(0, 7)));
    end
    return $urandom;
  endfunction

  initial begin
    int          n_ret;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    int          len;

    vecs[0] = '{"add_chain",
      '{enc_i(5,0,0,1), enc_i(3,0,0,2), enc_r(7'h00,2,1,0,3), enc_i(10,0,0,4),
        enc_r(7'h00,4,3,0,5), EBRK, 32'd0, 32'd0},
      6, 5, 5'd5, 32'd18, 1'b0, 32'h14};
    vecs[1] = '{"sub_slt",
      '{enc_i(3,0,0,1), enc_r(7'h20,1,0,0,2), enc_r(7'h00,0,2,2,3), enc_r(7'h00,0,2,3,4),
        EBRK, 32'd0, 32'd0, 32'd0},
      5, 4, 5'd4, 32'd0, 1'b0, 32'h10};
    vecs[2] = '{"x0_writes",
      '{enc_i(7,0,0,0), enc_r(7'h00,0,0,0,1), EBRK, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      3, 2, 5'd1, 32'd0, 1'b0, 32'h8};
    vecs[3] = '{"jal_illegal",
      '{32'h0000_006F, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      1, 0, 5'd0, 32'd0, 1'b1, 32'h0};
`ifdef RV_SHIFT_EN
    vecs[4] = '{"slli",
      '{enc_i(1,0,0,1), enc_i(4,1,1,2), EBRK, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      3, 2, 5'd2, 32'd16, 1'b0, 32'h8};
`else
    vecs[4] = '{"slli",
      '{enc_i(1,0,0,1), enc_i(4,1,1,2), EBRK, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      3, 1, 5'd1, 32'd1, 1'b1, 32'h4};
`endif
    vecs[5] = '{"imm_sext",
      '{enc_i(-1,0,0,1), enc_i(-1,0,3,2), enc_i(12'h7FF,1,4,3), EBRK,
        32'd0, 32'd0, 32'd0, 32'd0},
      4, 3, 5'd3, 32'hFFFF_F800, 1'b0, 32'hC};
    vecs[6] = '{"bad_funct7",
      '{enc_i(2,0,0,1), enc_r(7'h01,1,1,0,2), EBRK, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
      3, 1, 5'd1, 32'd2, 1'b1, 32'h4};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(i);
      run_case(n_ret, lrd, ldata);
      checkOutput({vecs[i].name, " retires"}, 64'(n_ret), 64'(vecs[i].exp_retires));
      if (vecs[i].exp_retires > 0) begin
        checkOutput({vecs[i].name, " last rd"}, lrd, vecs[i].exp_rd);
        checkOutput({vecs[i].name, " last data"}, ldata, vecs[i].exp_data);
      end
      checkOutput({vecs[i].name, " illegal"}, illegal, vecs[i].exp_ill);
      checkOutput({vecs[i].name, " final pc"}, pc, vecs[i].exp_pc);
    end

    // Reset asserted during EXECUTE and during WRITEBACK of ADDI x1,x0,9.
    for (int abort = 2; abort <= 3; abort++) begin
      clear_mem();
      mem[0] = enc_i(9, 0, 0, 1);
      mem[1] = EBRK;
      do_reset();
      repeat (abort) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput($sformatf("abort%0d pc", abort), pc, 64'd0);
      checkOutput($sformatf("abort%0d imem_addr", abort), bus_if.imem_addr, 64'd0);
      checkOutput($sformatf("abort%0d retire_valid", abort), bus_if.retire_valid, 64'd0);
      checkOutput($sformatf("abort%0d halted", abort), halted, 64'd0);
      mem[0] = enc_r(7'h00, 0, 1, 0, 2);
      run_case(n_ret, lrd, ldata);
      checkOutput($sformatf("abort%0d x1 readback", abort), ldata, 64'd0);
      checkOutput($sformatf("abort%0d retires", abort), 64'(n_ret), 64'd1);
    end

    // Random programs terminated by EBREAK.
    for (int t = 0; t < 25; t++) begin
      clear_mem();
      len = int'($urandom_range(3, 12));
      for (int k = 0; k < len; k++) mem[k] = rand_insn();
      mem[len] = EBRK;
      run_case(n_ret, lrd, ldata);
      checkOutput($sformatf("rand%0d retires", t), 64'(n_ret), 64'(exp_q.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
